ederah_rd_arbiter: RTL and testbench
====================================

EDERAH_RD_ARBITER -- requirements
Module: ederah_rd_arbiter

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 64, AXI read address width.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 512, AXI read data width.
REQ-003 SHALL have parameter C_MAX_OUTSTANDING, default 16, maximum accepted-but-incomplete bursts; power of 2, range 2..64.
REQ-004 SHALL have port ap_clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports sN_arvalid in 1, sN_arready out 1, sN_araddr in C_ADDR_WIDTH, sN_arlen in 8, for N=0 (NFA loader) and N=1 (query loader): requester AR channels.
REQ-007 SHALL have ports sN_rvalid out 1, sN_rready in 1, sN_rdata out C_DATA_WIDTH, sN_rlast out 1, for N=0,1: requester R channels.
REQ-008 SHALL have ports m_axi_arvalid out 1, m_axi_arready in 1, m_axi_araddr out C_ADDR_WIDTH, m_axi_arlen out 8: shared AR master.
REQ-009 SHALL have ports m_axi_rvalid in 1, m_axi_rready out 1, m_axi_rdata in C_DATA_WIDTH, m_axi_rlast in 1: shared R master.
REQ-010 SHALL have port idle  out  1  high when no AR is pending and no burst is outstanding.

Function
REQ-011 SHALL hold one AR output register (states EMPTY/LOADED); m_axi_arvalid=LOADED; the register returns to EMPTY on m_axi_arvalid&m_axi_arready.
REQ-012 SHALL grant a requester only when the register is EMPTY, or is emptied in the same cycle, and outstanding count < C_MAX_OUTSTANDING.
REQ-013 SHALL assert sN_arready combinationally in the granted cycle only; request-to-m_axi_arvalid latency exactly 1 cycle.
REQ-014 SHALL arbitrate round-robin: one requester valid -> grant it; both valid -> grant the one not granted last; last-grant pointer reset to 1 (s0 wins first tie).
REQ-015 SHALL pass araddr and arlen unmodified into the register and hold them stable while LOADED.
REQ-016 SHALL push the granted ID into an in-order tag FIFO of depth C_MAX_OUTSTANDING on grant, and increment the outstanding count ($clog2(C_MAX_OUTSTANDING)+1 bits).
REQ-017 SHALL route R beats to the requester at the tag FIFO head: sH_rvalid=m_axi_rvalid&~empty, m_axi_rready=sH_rready&~empty, rdata/rlast broadcast to both; non-head sN_rvalid=0.
REQ-018 SHALL pop the tag FIFO and decrement the count on m_axi_rvalid&m_axi_rready&m_axi_rlast.
REQ-019 SHALL apply grant-increment and rlast-decrement in the same cycle as net zero change.
REQ-020 SHALL hold m_axi_rready=0 while the tag FIFO is empty.
REQ-021 SHALL stall grants at count==C_MAX_OUTSTANDING and resume the cycle after a pop.
REQ-022 SHALL drive idle = ~LOADED & (count==0), registered-state based.

Reset
REQ-023 SHALL on ap_rst_n low, immediately and asynchronously: register EMPTY, count 0, FIFO empty, pointer 1; outputs m_axi_arvalid=0, m_axi_rready=0, sN_arready=0, sN_rvalid=0, idle=1; araddr/arlen/rdata/rlast 0.
REQ-024 SHALL discard all pending and in-flight bursts on reset mid-operation; beats arriving after reset release with an empty FIFO are not accepted.

Verification
REQ-025 SHALL verify: s0 request addr 0x1000 len 3, arready=1 -> m_axi_arvalid cycle+1, four beats routed to s0, s0_rlast on beat 4, idle=1 after.
REQ-026 SHALL verify: s0 and s1 continuously valid -> grant order s0,s1,s0,s1; R beats follow issue order.
REQ-027 SHALL verify: C_MAX_OUTSTANDING=4, five requests, no R data -> exactly 4 AR handshakes, 5th stalls; one rlast -> 5th issued next cycle.
REQ-028 SHALL verify: m_axi_arready=0 for 10 cycles -> araddr/arlen stable, no further grants.
REQ-029 SHALL verify: s1 holds rready=0 at head -> m_axi_rready=0, s0 receives nothing.
REQ-030 SHALL verify: ap_rst_n low mid-burst -> all outputs at reset values without waiting for a clock edge, idle=1.

Source files
------------

// File: rtl/ederah_rd_arbiter.sv
// Two-requester AXI read arbiter: round-robin AR grant into one output register,
// in-order tag FIFO steering R beats back to the requester that issued each burst.
module ederah_rd_arbiter #(
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_DATA_WIDTH      = 512,
    parameter int unsigned C_MAX_OUTSTANDING = 16
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,

    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    input  logic [C_ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]              s0_arlen,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    output logic [C_DATA_WIDTH-1:0] s0_rdata,
    output logic                    s0_rlast,

    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    input  logic [C_ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]              s1_arlen,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    output logic [C_DATA_WIDTH-1:0] s1_rdata,
    output logic                    s1_rlast,

    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [C_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                    m_axi_rlast,

    output logic                    idle
);

    localparam int unsigned AW = $clog2(C_MAX_OUTSTANDING);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] MaxCount = CW'(C_MAX_OUTSTANDING);

    typedef enum logic {
        AR_EMPTY  = 1'b0,
        AR_LOADED = 1'b1
    } arState_t;

    arState_t                     arState_q, arState_d;
    logic [C_ADDR_WIDTH-1:0]      arAddr_q, arAddr_d;
    logic [7:0]                   arLen_q, arLen_d;
    logic                         lastGrant_q, lastGrant_d;
    logic [CW-1:0]                count_q, count_d;
    logic [AW-1:0]                wrPtr_q, wrPtr_d;
    logic [AW-1:0]                rdPtr_q, rdPtr_d;
    logic [C_MAX_OUTSTANDING-1:0] tagMem_q, tagMem_d;

    logic arFire;
    logic canGrant;
    logic grant0;
    logic grant1;
    logic grantValid;
    logic fifoEmpty;
    logic headId;
    logic pop;

    assign arFire     = (arState_q == AR_LOADED) && m_axi_arready;
    // Gating with the reset input keeps arready low while reset is held.
    assign canGrant   = ap_rst_n && ((arState_q == AR_EMPTY) || arFire) && (count_q < MaxCount);
    assign grantValid = grant0 || grant1;
    assign fifoEmpty  = (count_q == '0);
    assign headId     = tagMem_q[rdPtr_q];
    assign pop        = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    // Round-robin: on a tie the requester not granted last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (canGrant) begin
            if (s0_arvalid && s1_arvalid) begin
                if (lastGrant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (s0_arvalid) begin
                grant0 = 1'b1;
            end else if (s1_arvalid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign s0_arready    = grant0;
    assign s1_arready    = grant1;
    assign m_axi_arvalid = (arState_q == AR_LOADED);
    assign m_axi_araddr  = arAddr_q;
    assign m_axi_arlen   = arLen_q;

    assign m_axi_rready = !fifoEmpty && (headId ? s1_rready : s0_rready);
    assign s0_rvalid    = m_axi_rvalid && !fifoEmpty && !headId;
    assign s1_rvalid    = m_axi_rvalid && !fifoEmpty && headId;
    // Data is zeroed while nothing is outstanding so reset shows clean outputs.
    assign s0_rdata     = fifoEmpty ? '0 : m_axi_rdata;
    assign s1_rdata     = fifoEmpty ? '0 : m_axi_rdata;
    assign s0_rlast     = !fifoEmpty && m_axi_rlast;
    assign s1_rlast     = !fifoEmpty && m_axi_rlast;

    assign idle = (arState_q == AR_EMPTY) && (count_q == '0);

    always_comb begin
        arState_d = arState_q;
        arAddr_d  = arAddr_q;
        arLen_d   = arLen_q;
        case (arState_q)
            AR_EMPTY: begin
                if (grantValid) begin
                    arState_d = AR_LOADED;
                end
            end
            AR_LOADED: begin
                if (arFire && !grantValid) begin
                    arState_d = AR_EMPTY;
                end
            end
            default: arState_d = AR_EMPTY;
        endcase
        if (grant0) begin
            arAddr_d = s0_araddr;
            arLen_d  = s0_arlen;
        end else if (grant1) begin
            arAddr_d = s1_araddr;
            arLen_d  = s1_arlen;
        end
    end

    always_comb begin
        lastGrant_d = lastGrant_q;
        tagMem_d    = tagMem_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        if (grantValid) begin
            lastGrant_d       = grant1;
            tagMem_d[wrPtr_q] = grant1;
            wrPtr_d           = wrPtr_q + AW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({grantValid, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            arState_q   <= AR_EMPTY;
            arAddr_q    <= '0;
            arLen_q     <= '0;
            lastGrant_q <= 1'b1;
            count_q     <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            tagMem_q    <= '0;
        end else begin
            arState_q   <= arState_d;
            arAddr_q    <= arAddr_d;
            arLen_q     <= arLen_d;
            lastGrant_q <= lastGrant_d;
            count_q     <= count_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            tagMem_q    <= tagMem_d;
        end
    end

endmodule

// File: tb/tb_ederah_rd_arbiter.sv
// Directed bench for ederah_rd_arbiter with a four-deep outstanding limit.
module tb_ederah_rd_arbiter;

    localparam int AW_T = 64;
    localparam int DW_T = 64;

    logic            ap_clk;
    logic            ap_rst_n;
    logic            s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
    logic [AW_T-1:0] s0_araddr;
    logic [7:0]      s0_arlen;
    logic [DW_T-1:0] s0_rdata;
    logic            s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
    logic [AW_T-1:0] s1_araddr;
    logic [7:0]      s1_arlen;
    logic [DW_T-1:0] s1_rdata;
    logic            m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [AW_T-1:0] m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic [DW_T-1:0] m_axi_rdata;
    logic            idle;

    int errCount;
    int checkCount;
    int arHs;
    int grantQ[$];
    int hsBase;
    int gBase;

    ederah_rd_arbiter #(
        .C_ADDR_WIDTH(AW_T),
        .C_DATA_WIDTH(DW_T),
        .C_MAX_OUTSTANDING(4)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .s0_arvalid(s0_arvalid),
        .s0_arready(s0_arready),
        .s0_araddr(s0_araddr),
        .s0_arlen(s0_arlen),
        .s0_rvalid(s0_rvalid),
        .s0_rready(s0_rready),
        .s0_rdata(s0_rdata),
        .s0_rlast(s0_rlast),
        .s1_arvalid(s1_arvalid),
        .s1_arready(s1_arready),
        .s1_araddr(s1_araddr),
        .s1_arlen(s1_arlen),
        .s1_rvalid(s1_rvalid),
        .s1_rready(s1_rready),
        .s1_rdata(s1_rdata),
        .s1_rlast(s1_rlast),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen),
        .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata),
        .m_axi_rlast(m_axi_rlast),
        .idle(idle)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Records AR handshakes and the order in which requesters were granted.
    always @(posedge ap_clk) begin
        if (ap_rst_n && m_axi_arvalid && m_axi_arready) arHs++;
        if (s0_arvalid && s0_arready) grantQ.push_back(0);
        if (s1_arvalid && s1_arready) grantQ.push_back(1);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [63:0] a0, input logic [7:0] l0,
                                 input logic v1, input logic [63:0] a1, input logic [7:0] l1);
        s0_arvalid = v0;
        s0_araddr  = a0;
        s0_arlen   = l0;
        s1_arvalid = v1;
        s1_araddr  = a1;
        s1_arlen   = l1;
    endtask

    task automatic applyReset();
        applyStimulus(0, 0, 0, 0, 0, 0);
        m_axi_arready = 0;
        m_axi_rvalid  = 0;
        m_axi_rlast   = 0;
        m_axi_rdata   = 0;
        s0_rready     = 0;
        s1_rready     = 0;
        ap_rst_n      = 0;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1;
        nextCycle();
    endtask

    // One R beat; checks it lands only on the expected requester.
    task automatic driveBeat(input logic [63:0] d, input logic last, input logic toS1);
        m_axi_rvalid = 1;
        m_axi_rdata  = d;
        m_axi_rlast  = last;
        #1;
        checkOutput("beat_s0_rvalid", s0_rvalid, !toS1);
        checkOutput("beat_s1_rvalid", s1_rvalid, toS1);
        checkOutput("beat_rdata", toS1 ? s1_rdata : s0_rdata, d);
        checkOutput("beat_rlast", toS1 ? s1_rlast : s0_rlast, last);
        checkOutput("beat_m_rready", m_axi_rready, 1);
        nextCycle();
        m_axi_rvalid = 0;
        m_axi_rlast  = 0;
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        arHs       = 0;
        applyStimulus(1, 'h1234, 5, 0, 0, 0);
        m_axi_arready = 1;
        m_axi_rvalid  = 1;
        m_axi_rlast   = 1;
        m_axi_rdata   = 'hDEAD;
        s0_rready     = 1;
        s1_rready     = 1;
        ap_rst_n      = 0;
        #3;
        checkOutput("rst_idle", idle, 1);
        checkOutput("rst_arvalid", m_axi_arvalid, 0);
        checkOutput("rst_s0_arready", s0_arready, 0);
        checkOutput("rst_m_rready", m_axi_rready, 0);
        checkOutput("rst_s0_rvalid", s0_rvalid, 0);
        checkOutput("rst_s0_rdata", s0_rdata, 0);
        checkOutput("rst_araddr", m_axi_araddr, 0);

        // Single burst from s0.
        applyReset();
        m_axi_arready = 1;
        applyStimulus(1, 'h1000, 3, 0, 0, 0);
        #1;
        checkOutput("t1_s0_arready", s0_arready, 1);
        checkOutput("t1_arvalid_pre", m_axi_arvalid, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t1_arvalid", m_axi_arvalid, 1);
        checkOutput("t1_araddr", m_axi_araddr, 'h1000);
        checkOutput("t1_arlen", m_axi_arlen, 3);
        checkOutput("t1_idle_busy", idle, 0);
        nextCycle();
        checkOutput("t1_arvalid_done", m_axi_arvalid, 0);
        s0_rready = 1;
        for (int i = 0; i < 4; i++) driveBeat(64'h100 + 64'(i), (i == 3), 0);
        #1;
        checkOutput("t1_idle_after", idle, 1);

        // Tie between requesters alternates, capped at four outstanding.
        applyReset();
        m_axi_arready = 1;
        s0_rready = 1;
        s1_rready = 1;
        gBase = grantQ.size();
        applyStimulus(1, 'hA0, 0, 1, 'hB0, 0);
        repeat (6) nextCycle();
        #1;
        checkOutput("t2_grant_count", 64'(grantQ.size() - gBase), 4);
        for (int i = 0; i < 4; i++) checkOutput("t2_grant_order", 64'(grantQ[gBase + i]), 64'(i % 2));
        checkOutput("t2_full_s0", s0_arready, 0);
        checkOutput("t2_full_s1", s1_arready, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        driveBeat('h11, 1, 0);
        driveBeat('h22, 1, 1);
        driveBeat('h33, 1, 0);
        driveBeat('h44, 1, 1);
        #1;
        checkOutput("t2_idle", idle, 1);

        // Outstanding limit: fifth request waits for one rlast.
        applyReset();
        m_axi_arready = 1;
        hsBase = arHs;
        applyStimulus(1, 'h3000, 0, 0, 0, 0);
        repeat (4) nextCycle();
        #1;
        checkOutput("t3_stall", s0_arready, 0);
        repeat (3) nextCycle();
        checkOutput("t3_hs4", 64'(arHs - hsBase), 4);
        checkOutput("t3_still_stall", s0_arready, 0);
        s0_rready    = 1;
        m_axi_rvalid = 1;
        m_axi_rlast  = 1;
        #1;
        checkOutput("t3_pop_cycle_stall", s0_arready, 0);
        nextCycle();
        m_axi_rvalid = 0;
        m_axi_rlast  = 0;
        #1;
        checkOutput("t3_resume", s0_arready, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t3_arvalid5", m_axi_arvalid, 1);
        nextCycle();
        checkOutput("t3_hs5", 64'(arHs - hsBase), 5);

        // Back-pressure on AR: register holds, no further grants.
        applyReset();
        m_axi_arready = 0;
        applyStimulus(1, 'h2222, 7, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 'h4444, 2);
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput("t4_araddr", m_axi_araddr, 'h2222);
            checkOutput("t4_arlen", m_axi_arlen, 7);
            checkOutput("t4_s1_blocked", s1_arready, 0);
            nextCycle();
        end
        m_axi_arready = 1;
        #1;
        checkOutput("t4_same_cycle_grant", s1_arready, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t4_araddr2", m_axi_araddr, 'h4444);
        checkOutput("t4_arlen2", m_axi_arlen, 2);
        nextCycle();
        s0_rready = 1;
        s1_rready = 1;
        driveBeat('h66, 1, 0);
        driveBeat('h77, 1, 1);
        #1;
        checkOutput("t4_idle", idle, 1);

        // Head requester s1 stalls R; s0 must see nothing.
        applyReset();
        m_axi_arready = 1;
        applyStimulus(0, 0, 0, 1, 'h5000, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        s0_rready    = 1;
        s1_rready    = 0;
        m_axi_rvalid = 1;
        m_axi_rlast  = 1;
        m_axi_rdata  = 'h55;
        repeat (3) begin
            #1;
            checkOutput("t5_m_rready", m_axi_rready, 0);
            checkOutput("t5_s0_rvalid", s0_rvalid, 0);
            checkOutput("t5_s1_rvalid", s1_rvalid, 1);
            nextCycle();
        end
        s1_rready = 1;
        #1;
        checkOutput("t5_release", m_axi_rready, 1);
        nextCycle();
        m_axi_rvalid = 0;
        #1;
        checkOutput("t5_idle", idle, 1);
        m_axi_rvalid = 1;
        #1;
        checkOutput("t5_empty_rready", m_axi_rready, 0);
        checkOutput("t5_empty_s0_rvalid", s0_rvalid, 0);
        m_axi_rvalid = 0;
        m_axi_rlast  = 0;

        // Reset asserted mid-burst acts without a clock edge.
        applyReset();
        m_axi_arready = 1;
        applyStimulus(1, 'h6000, 3, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(1, 'h7000, 1, 0, 0, 0);
        s0_rready    = 1;
        m_axi_rvalid = 1;
        m_axi_rdata  = 'h77;
        #1;
        checkOutput("t6_pre_rvalid", s0_rvalid, 1);
        #1;
        ap_rst_n = 0;
        #1;
        checkOutput("t6_arvalid", m_axi_arvalid, 0);
        checkOutput("t6_s0_arready", s0_arready, 0);
        checkOutput("t6_m_rready", m_axi_rready, 0);
        checkOutput("t6_s0_rvalid", s0_rvalid, 0);
        checkOutput("t6_s0_rdata", s0_rdata, 0);
        checkOutput("t6_araddr", m_axi_araddr, 0);
        checkOutput("t6_arlen", m_axi_arlen, 0);
        checkOutput("t6_idle", idle, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1;
        #1;
        checkOutput("t6_post_m_rready", m_axi_rready, 0);
        checkOutput("t6_post_s0_rvalid", s0_rvalid, 0);
        m_axi_rvalid = 0;
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
